// File: rtl/uc.sv
// Main control unit: registered decode of the 6-bit opcode into data-path controls.
// Optional UC_ILLEGAL_FLAG_EN adds Illegal / IllegalSticky outputs for unrecognised opcodes.
module uc #(
  parameter logic [2:0] NOP_ALUOP = 3'b000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  output logic       MemToReg,
  output logic       RegWrite,
  output logic       MemToWrite,
  output logic [2:0] ALUOp,
  output logic       RegDst,
  output logic       ALUSrc,
  output logic       Branch,
  output logic       Jump
`ifdef UC_ILLEGAL_FLAG_EN
  ,
  output logic       Illegal,
  output logic       IllegalSticky
`endif
);

  logic       mem_to_reg_d, mem_to_reg_q;
  logic       reg_write_d, reg_write_q;
  logic       mem_to_write_d, mem_to_write_q;
  logic [2:0] alu_op_d, alu_op_q;
  logic       reg_dst_d, reg_dst_q;
  logic       alu_src_d, alu_src_q;
  logic       branch_d, branch_q;
  logic       jump_d, jump_q;
  logic       illegal_d;

  always_comb begin
    mem_to_reg_d   = 1'b0;
    reg_write_d    = 1'b0;
    mem_to_write_d = 1'b0;
    alu_op_d       = NOP_ALUOP;
    reg_dst_d      = 1'b0;
    alu_src_d      = 1'b0;
    branch_d       = 1'b0;
    jump_d         = 1'b0;
    illegal_d      = 1'b0;
    case (opcode)
      6'b000000: begin reg_write_d = 1'b1; alu_op_d = 3'b010; reg_dst_d = 1'b1; end
      6'b100011: begin mem_to_reg_d = 1'b1; reg_write_d = 1'b1; alu_op_d = 3'b000; alu_src_d = 1'b1; end
      6'b101011: begin mem_to_write_d = 1'b1; alu_op_d = 3'b000; alu_src_d = 1'b1; end
      6'b000100: begin alu_op_d = 3'b001; branch_d = 1'b1; end
      6'b001000: begin reg_write_d = 1'b1; alu_op_d = 3'b000; alu_src_d = 1'b1; end
      6'b001100: begin reg_write_d = 1'b1; alu_op_d = 3'b011; alu_src_d = 1'b1; end
      6'b001101: begin reg_write_d = 1'b1; alu_op_d = 3'b100; alu_src_d = 1'b1; end
      6'b001010: begin reg_write_d = 1'b1; alu_op_d = 3'b101; alu_src_d = 1'b1; end
      6'b000010: begin jump_d = 1'b1; end
      default:   begin illegal_d = 1'b1; end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_to_reg_q   <= 1'b0;
      reg_write_q    <= 1'b0;
      mem_to_write_q <= 1'b0;
      alu_op_q       <= NOP_ALUOP;
      reg_dst_q      <= 1'b0;
      alu_src_q      <= 1'b0;
      branch_q       <= 1'b0;
      jump_q         <= 1'b0;
    end else begin
      mem_to_reg_q   <= mem_to_reg_d;
      reg_write_q    <= reg_write_d;
      mem_to_write_q <= mem_to_write_d;
      alu_op_q       <= alu_op_d;
      reg_dst_q      <= reg_dst_d;
      alu_src_q      <= alu_src_d;
      branch_q       <= branch_d;
      jump_q         <= jump_d;
    end
  end

  assign MemToReg   = mem_to_reg_q;
  assign RegWrite   = reg_write_q;
  assign MemToWrite = mem_to_write_q;
  assign ALUOp      = alu_op_q;
  assign RegDst     = reg_dst_q;
  assign ALUSrc     = alu_src_q;
  assign Branch     = branch_q;
  assign Jump       = jump_q;

`ifdef UC_ILLEGAL_FLAG_EN
  logic illegal_q;
  logic illegal_sticky_d, illegal_sticky_q;

  // Sticky flag latches the first unrecognised opcode until the next reset.
  assign illegal_sticky_d = illegal_sticky_q | illegal_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      illegal_q        <= 1'b0;
      illegal_sticky_q <= 1'b0;
    end else begin
      illegal_q        <= illegal_d;
      illegal_sticky_q <= illegal_sticky_d;
    end
  end

  assign Illegal       = illegal_q;
  assign IllegalSticky = illegal_sticky_q;
`else
  logic unused_illegal;
  assign unused_illegal = illegal_d;
`endif

endmodule

// File: tb/tb_uc.sv
// Scoreboard bench for uc: stimulus queues expected controls, monitor checks one cycle later.
module tb_uc;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [5:0] opcode = 6'b000000;
  logic       MemToReg, RegWrite, MemToWrite, RegDst, ALUSrc, Branch, Jump;
  logic [2:0] ALUOp;
  logic       ill_act, sticky_act;

  always #5 clk = ~clk;

  uc #(.NOP_ALUOP(3'b000)) dut (
    .clk(clk), .rst(rst), .opcode(opcode),
    .MemToReg(MemToReg), .RegWrite(RegWrite), .MemToWrite(MemToWrite),
    .ALUOp(ALUOp), .RegDst(RegDst), .ALUSrc(ALUSrc), .Branch(Branch), .Jump(Jump)
`ifdef UC_ILLEGAL_FLAG_EN
    , .Illegal(ill_act), .IllegalSticky(sticky_act)
`endif
  );

`ifndef UC_ILLEGAL_FLAG_EN
  assign ill_act    = 1'b0;
  assign sticky_act = 1'b0;
`endif

  typedef struct {
    string      name;
    logic [11:0] vec;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   sticky_m = 1'b0;
  bit   stim_done = 1'b0;

  // {Illegal, IllegalSticky, MemToReg, RegWrite, MemToWrite, ALUOp, RegDst, ALUSrc, Branch, Jump}
  function automatic logic [11:0] actual();
    return {ill_act, sticky_act, MemToReg, RegWrite, MemToWrite, ALUOp, RegDst, ALUSrc, Branch, Jump};
  endfunction

  task automatic check(input string nm, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end else begin
      $display("ok   %s: %b", nm, act);
    end
  endtask

  task automatic push_exp(input string nm, input logic [9:0] ctl, input bit ill);
    exp_t e;
    bit   ill_e, st_e;
    if (ill) sticky_m = 1'b1;
`ifdef UC_ILLEGAL_FLAG_EN
    ill_e = ill;
    st_e  = sticky_m;
`else
    ill_e = 1'b0;
    st_e  = 1'b0;
`endif
    e.name = nm;
    e.vec  = {ill_e, st_e, ctl};
    exp_q.push_back(e);
  endtask

  task automatic issue(input string nm, input logic [5:0] op, input logic [9:0] ctl, input bit ill);
    @(negedge clk);
    opcode = op;
    push_exp(nm, ctl, ill);
  endtask

  // Monitor: every edge, compare the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check(e.name, actual(), e.vec);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int budget;
    // Let the DUT run, then assert reset mid-cycle and check it acts immediately.
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b1;
    sticky_m = 1'b0;
    #1;
    check("reset_async", actual(), 12'b0);
    @(posedge clk);
    #1;
    check("reset_held_edge", actual(), 12'b0);
    @(negedge clk);
    rst = 1'b0;
    opcode = 6'b000000;
    push_exp("rtype_after_rst", 10'b0_1_0_010_1_0_0_0, 1'b0);

    issue("j",      6'b000010, 10'b0_0_0_000_0_0_0_1, 1'b0);
    issue("addi",   6'b001000, 10'b0_1_0_000_0_1_0_0, 1'b0);
    issue("lw",     6'b100011, 10'b1_1_0_000_0_1_0_0, 1'b0);
    issue("sw",     6'b101011, 10'b0_0_1_000_0_1_0_0, 1'b0);
    issue("unk_3f", 6'b111111, 10'b0,                 1'b1);
    issue("rtype",  6'b000000, 10'b0_1_0_010_1_0_0_0, 1'b0);
    issue("beq",    6'b000100, 10'b0_0_0_001_0_0_1_0, 1'b0);
    issue("ori",    6'b001101, 10'b0_1_0_100_0_1_0_0, 1'b0);
    issue("slti",   6'b001010, 10'b0_1_0_101_0_1_0_0, 1'b0);
    issue("andi",   6'b001100, 10'b0_1_0_011_0_1_0_0, 1'b0);
    issue("unk_15", 6'b010101, 10'b0,                 1'b1);
    issue("unk_01", 6'b000001, 10'b0,                 1'b1);
    issue("lw2",    6'b100011, 10'b1_1_0_000_0_1_0_0, 1'b0);

    budget = 10;
    while (exp_q.size() > 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      exp_q.delete();
    end

    // Mid-stream reset while outputs are non-zero must clear everything, sticky included.
    #2;
    rst = 1'b1;
    sticky_m = 1'b0;
    #1;
    check("reset_midstream", actual(), 12'b0);
    @(negedge clk);
    rst = 1'b0;
    opcode = 6'b001101;
    push_exp("ori_after_rst", 10'b0_1_0_100_0_1_0_0, 1'b0);
    issue("sw2",    6'b101011, 10'b0_0_1_000_0_1_0_0, 1'b0);
    issue("beq2",   6'b000100, 10'b0_0_0_001_0_0_1_0, 1'b0);

    budget = 10;
    while (exp_q.size() > 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_end: %0d expectations left, required 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
